data_bus_arbiter: RTL and testbench

Two-master arbiter and address decoder for the core's data-memory bus. It shares the RAM, RTC and testbench-register slaves between the CPU data port (master 0) and a secondary master (master 1, e.g. DMA or debug loader). It grants one access per cycle, round-robin with optional lock. It drives the selected slave's enable, and returns read data one cycle later through a registered response route.

---
 rtl/data_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter with address decode and a registered read-response route.
// Round-robin between masters with optional per-master lock; read data returns one cycle after grant.
module data_bus_arbiter #(
  parameter logic [3:0] RAM_LIMIT = 4'h2,
  parameter logic [3:0] RTC_LIMIT = 4'h8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      m_req_i,
  input  logic [1:0]      m_lock_i,
  input  logic [1:0][31:0] m_addr_i,
  input  logic [1:0][3:0] m_we_i,
  input  logic [1:0][31:0] m_wdata_i,
  output logic [1:0]      m_gnt_o,
  output logic [1:0]      m_stall_o,
  output logic [1:0]      m_rvalid_o,
  output logic [31:0]     m_rdata_o,
  output logic            s_ram_en_o,
  output logic            s_rtc_en_o,
  output logic            s_tb_en_o,
  output logic [31:0]     s_addr_o,
  output logic [3:0]      s_we_o,
  output logic [31:0]     s_wdata_o,
  input  logic [31:0]     s_ram_rdata_i,
  input  logic [31:0]     s_rtc_rdata_i,
  input  logic [31:0]     s_tb_rdata_i,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] SL_RAM = 2'd0;
  localparam logic [1:0] SL_RTC = 2'd1;
  localparam logic [1:0] SL_TB  = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_gnt;
  logic        w_last_nxt;
  logic [1:0]  w_gnt;
  logic        w_win;
  logic        w_any;
  logic [1:0]  w_slave;

  logic        r_resp_read;
  logic        r_resp_master;
  logic [1:0]  r_resp_slave;

  // Grant is gated by reset so nothing reaches a slave while reset is held.
  always_comb begin
    w_gnt       = 2'b00;
    w_state_nxt = IDLE;
    w_last_nxt  = r_last_gnt;
    w_win       = 1'b0;
    if (reset) begin
      if (r_state == OWN0 && m_req_i[0]) begin
        w_gnt = 2'b01;
      end else if (r_state == OWN1 && m_req_i[1]) begin
        w_gnt = 2'b10;
      end else begin
        case (m_req_i)
          2'b01:   w_gnt = 2'b01;
          2'b10:   w_gnt = 2'b10;
          2'b11:   w_gnt = r_last_gnt ? 2'b01 : 2'b10;
          default: w_gnt = 2'b00;
        endcase
      end
      if (w_gnt != 2'b00) begin
        w_win      = w_gnt[1];
        w_last_nxt = w_win;
        if (m_lock_i[w_win]) w_state_nxt = w_win ? OWN1 : OWN0;
      end
    end
  end

  assign w_any     = |w_gnt;
  assign m_gnt_o   = w_gnt;
  assign m_stall_o = m_req_i & ~w_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
    end
  end

  assign dbg_state_o = r_state;

  always_comb begin
    s_addr_o  = 32'h0;
    s_we_o    = 4'h0;
    s_wdata_o = 32'h0;
    if (w_any) begin
      s_addr_o  = m_addr_i[w_win];
      s_we_o    = m_we_i[w_win];
      s_wdata_o = m_wdata_i[w_win];
    end
  end

  always_comb begin
    if (s_addr_o[31:28] < RAM_LIMIT)      w_slave = SL_RAM;
    else if (s_addr_o[31:28] < RTC_LIMIT) w_slave = SL_RTC;
    else                                  w_slave = SL_TB;
  end

  assign s_ram_en_o = w_any && (w_slave == SL_RAM);
  assign s_rtc_en_o = w_any && (w_slave == SL_RTC);
  assign s_tb_en_o  = w_any && (w_slave == SL_TB);

  // Response route: remembers who asked and which slave answers next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_read   <= 1'b0;
      r_resp_master <= 1'b0;
      r_resp_slave  <= SL_RAM;
    end else begin
      r_resp_read   <= w_any && (s_we_o == 4'h0);
      r_resp_master <= w_win;
      r_resp_slave  <= w_slave;
    end
  end

  assign m_rvalid_o = r_resp_read ? (r_resp_master ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    m_rdata_o = 32'h0;
    if (r_resp_read) begin
      case (r_resp_slave)
        SL_RAM:  m_rdata_o = s_ram_rdata_i;
        SL_RTC:  m_rdata_o = s_rtc_rdata_i;
        default: m_rdata_o = s_tb_rdata_i;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed arbitration/decode cycles plus a random single-master
// read phase; read responses are predicted into a queue and compared one cycle later.
module tb_data_bus_arbiter;

  localparam logic [31:0] RAM_DATA = 32'hDEADBEEF;
  localparam logic [31:0] RTC_DATA = 32'h00001234;
  localparam logic [31:0] TB_DATA  = 32'hCAFEF00D;

  logic             clk;
  logic             reset;
  logic [1:0]       m_req_i;
  logic [1:0]       m_lock_i;
  logic [1:0][31:0] m_addr_i;
  logic [1:0][3:0]  m_we_i;
  logic [1:0][31:0] m_wdata_i;
  logic [1:0]       m_gnt_o;
  logic [1:0]       m_stall_o;
  logic [1:0]       m_rvalid_o;
  logic [31:0]      m_rdata_o;
  logic             s_ram_en_o;
  logic             s_rtc_en_o;
  logic             s_tb_en_o;
  logic [31:0]      s_addr_o;
  logic [3:0]       s_we_o;
  logic [31:0]      s_wdata_o;
  logic [31:0]      s_ram_rdata_i;
  logic [31:0]      s_rtc_rdata_i;
  logic [31:0]      s_tb_rdata_i;
  logic [1:0]       dbg_state_o;

  logic [33:0] exp_q[$];
  int n_checks;
  int n_errors;

  data_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m_req_i(m_req_i), .m_lock_i(m_lock_i), .m_addr_i(m_addr_i),
    .m_we_i(m_we_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_stall_o(m_stall_o),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_ram_en_o(s_ram_en_o), .s_rtc_en_o(s_rtc_en_o), .s_tb_en_o(s_tb_en_o),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
    .s_ram_rdata_i(s_ram_rdata_i), .s_rtc_rdata_i(s_rtc_rdata_i),
    .s_tb_rdata_i(s_tb_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Decode written from the memory map: top nibble 0-1 RAM, 2-7 RTC, 8-F TB. Bits {tb,rtc,ram}.
  function automatic logic [2:0] map_en(input logic [31:0] addr);
    logic [3:0] nib;
    nib = addr[31:28];
    if (nib <= 4'h1)      return 3'b001;
    else if (nib <= 4'h7) return 3'b010;
    else                  return 3'b100;
  endfunction

  function automatic logic [31:0] map_data(input logic [31:0] addr);
    case (map_en(addr))
      3'b001:  return RAM_DATA;
      3'b010:  return RTC_DATA;
      default: return TB_DATA;
    endcase
  endfunction

  function automatic logic [33:0] rd_resp(input int m, input logic [31:0] addr);
    logic [1:0] oh;
    oh = (m == 1) ? 2'b10 : 2'b01;
    return {oh, map_data(addr)};
  endfunction

  // driver tasks
  task automatic drive(input int m, input logic [31:0] addr, input logic [3:0] we,
                       input logic [31:0] wdata);
    m_addr_i[m]  = addr;
    m_we_i[m]    = we;
    m_wdata_i[m] = wdata;
  endtask

  task automatic set_req(input logic [1:0] req, input logic [1:0] lock);
    m_req_i  = req;
    m_lock_i = lock;
  endtask

  // One bus cycle: score the response due now, check the request-phase outputs, queue the
  // response expected next cycle, then advance to just after the rising edge.
  task automatic cycle(input string tag, input logic [1:0] exp_gnt, input logic [33:0] next_resp);
    logic [33:0] e;
    logic [31:0] ea;
    logic [3:0]  ew;
    logic [31:0] ed;
    logic [2:0]  een;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_rvalid"}, {32'h0, m_rvalid_o}, {32'h0, e[33:32]});
      check_eq({tag, "_rdata"}, {2'b0, m_rdata_o}, {2'b0, e[31:0]});
    end
    ea = 32'h0; ew = 4'h0; ed = 32'h0; een = 3'b000;
    if (exp_gnt == 2'b01) begin ea = m_addr_i[0]; ew = m_we_i[0]; ed = m_wdata_i[0]; end
    if (exp_gnt == 2'b10) begin ea = m_addr_i[1]; ew = m_we_i[1]; ed = m_wdata_i[1]; end
    if (exp_gnt != 2'b00) een = map_en(ea);
    check_eq({tag, "_gnt"}, {32'h0, m_gnt_o}, {32'h0, exp_gnt});
    check_eq({tag, "_stall"}, {32'h0, m_stall_o}, {32'h0, m_req_i & ~exp_gnt});
    check_eq({tag, "_en"}, {31'h0, s_tb_en_o, s_rtc_en_o, s_ram_en_o}, {31'h0, een});
    check_eq({tag, "_saddr"}, {2'b0, s_addr_o}, {2'b0, ea});
    check_eq({tag, "_swe"}, {30'h0, s_we_o}, {30'h0, ew});
    check_eq({tag, "_swdata"}, {2'b0, s_wdata_o}, {2'b0, ed});
    exp_q.push_back(next_resp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    s_ram_rdata_i = RAM_DATA;
    s_rtc_rdata_i = RTC_DATA;
    s_tb_rdata_i  = TB_DATA;
    reset = 1'b0;
    set_req(2'b11, 2'b00);
    drive(0, 32'h0000_0100, 4'h0, 32'h0);
    drive(1, 32'h0000_0100, 4'h0, 32'h0);
    exp_q.push_back(34'h0);

    // held in reset with both requesting: no grant, stall mirrors request
    cycle("rst", 2'b00, 34'h0);
    check_eq("rst_state", {32'h0, dbg_state_o}, 34'd0);
    reset = 1'b1;

    // same-address tie alternates, master 0 first
    cycle("tie0", 2'b01, rd_resp(0, 32'h0000_0100));
    cycle("tie1", 2'b10, rd_resp(1, 32'h0000_0100));
    cycle("tie2", 2'b01, rd_resp(0, 32'h0000_0100));

    // master 0 single RAM read
    set_req(2'b01, 2'b00);
    cycle("m0_rd", 2'b01, rd_resp(0, 32'h0000_0100));

    // master 1 writes: TB then RTC, no response
    set_req(2'b10, 2'b00);
    drive(1, 32'h8000_1000, 4'hF, 32'h41);
    cycle("m1_wr_tb", 2'b10, 34'h0);
    drive(1, 32'h2000_0000, 4'hF, 32'h99);
    cycle("m1_wr_rtc", 2'b10, 34'h0);

    // master 1 takes the lock, then holds it through three ties
    drive(1, 32'h2000_0010, 4'h0, 32'h0);
    set_req(2'b10, 2'b10);
    cycle("lk_take", 2'b10, rd_resp(1, 32'h2000_0010));
    check_eq("lk_state", {32'h0, dbg_state_o}, 34'd2);
    set_req(2'b11, 2'b10);
    for (int i = 0; i < 3; i++) cycle("lk_hold", 2'b10, rd_resp(1, 32'h2000_0010));
    set_req(2'b11, 2'b00);
    cycle("lk_drop", 2'b10, rd_resp(1, 32'h2000_0010));
    cycle("lk_after", 2'b01, rd_resp(0, 32'h0000_0100));

    // back-to-back: m0 RAM read then m1 RTC read
    set_req(2'b01, 2'b00);
    cycle("b2b_ram", 2'b01, rd_resp(0, 32'h0000_0100));
    set_req(2'b10, 2'b00);
    cycle("b2b_rtc", 2'b10, rd_resp(1, 32'h2000_0010));
    set_req(2'b00, 2'b00);
    cycle("idle", 2'b00, 34'h0);

    // owner drops request while locked: other master is served the same cycle
    set_req(2'b01, 2'b01);
    cycle("own0", 2'b01, rd_resp(0, 32'h0000_0100));
    set_req(2'b10, 2'b00);
    cycle("own0_rel", 2'b10, rd_resp(1, 32'h2000_0010));

    // reset right after a read grant discards the pending response
    set_req(2'b01, 2'b00);
    cycle("pre_rst", 2'b01, rd_resp(0, 32'h0000_0100));
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(34'h0);
    cycle("mid_rst", 2'b00, 34'h0);
    check_eq("mid_rst_state", {32'h0, dbg_state_o}, 34'd0);
    reset = 1'b1;
    set_req(2'b00, 2'b00);
    cycle("post_rst", 2'b00, 34'h0);
    set_req(2'b11, 2'b00);
    cycle("post_rst_tie", 2'b01, rd_resp(0, 32'h0000_0100));

    // random single-master reads across the whole address map
    for (int i = 0; i < 24; i++) begin
      int m;
      logic [31:0] a;
      m = $urandom_range(0, 1);
      a = {4'($urandom_range(0, 15)), 28'($urandom)};
      drive(m, a, 4'h0, 32'h0);
      set_req((m == 1) ? 2'b10 : 2'b01, 2'b00);
      cycle("rnd", (m == 1) ? 2'b10 : 2'b01, rd_resp(m, a));
    end
    set_req(2'b00, 2'b00);
    cycle("drain", 2'b00, 34'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
